branch_resolve_unit: RTL and testbench

- EX-stage companion to the 2-bit branch predictor.
- Captures each branch's prediction context when it leaves ID and carries it into EX. In EX it compares the prediction with the actual outcome.
- Drives the predictor's EX-side inputs: EX_Branch, next counter state (update) and rollback request (rbk). Also supplies the rollback PC to the PC mux.
- Keeps saturating statistics counters for branches and mispredicts.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/sat_counter.sv | 26 ++
 rtl/branch_resolve_unit.sv | 89 ++++++++
 tb/tb_branch_resolve_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared 2-bit branch-predictor definitions: counter encoding, the saturating
// counter update rule, and the sequential PC increment.
package bp_pkg;

    typedef logic [1:0] bp_state_t;

    localparam bp_state_t ST_SNT = 2'b00;
    localparam bp_state_t ST_WNT = 2'b01;
    localparam bp_state_t ST_WT  = 2'b10;
    localparam bp_state_t ST_ST  = 2'b11;

    localparam int unsigned PC_INC = 4;

    // Move one step toward the actual outcome, pinned at the strong ends.
    function automatic bp_state_t sat_update(input bp_state_t state, input logic taken);
        bp_state_t nxt;
        nxt = state;
        if (taken) begin
            if (state != ST_ST) nxt = state + 2'b01;
        end else begin
            if (state != ST_SNT) nxt = state - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that increments on inc_i and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries ID prediction context into EX, checks it
// against the real outcome, and drives predictor update / rollback.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         CNT_W      = 32,
    parameter logic [1:0] INIT_STATE = 2'b11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ID_Branch_i,
    input  logic [ADDR_W-1:0] ID_pc_i,
    input  logic [ADDR_W-1:0] ID_target_i,
    input  logic [1:0]        state_i,
    input  logic              EX_taken_i,
    output logic              EX_Branch_o,
    output logic [1:0]        update_o,
    output logic              rbk_o,
    output logic [ADDR_W-1:0] rbk_addr_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target_q;
    bp_state_t         state_q;
    logic              pred_q;

    logic      capture;
    bp_state_t cap_state;
    bp_state_t update;
    logic      rbk;

    always_comb begin
        update = state_q;
        if (valid_q) update = sat_update(state_q, EX_taken_i);
    end

    assign rbk     = valid_q & (pred_q != EX_taken_i);
    assign capture = ID_Branch_i & ~stall_i & ~flush_i & ~rbk;
    // The predictor commits update_o only at this edge, so forward it.
    assign cap_state = valid_q ? update : bp_state_t'(state_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            target_q <= '0;
            state_q  <= bp_state_t'(INIT_STATE);
            pred_q   <= INIT_STATE[1];
        end else begin
            valid_q <= capture;
            if (capture) begin
                pc_q     <= ID_pc_i;
                target_q <= ID_target_i;
                state_q  <= cap_state;
                pred_q   <= cap_state[1];
            end
        end
    end

    always_comb begin
        rbk_addr_o = '0;
        if (rbk) rbk_addr_o = pred_q ? (pc_q + ADDR_W'(PC_INC)) : target_q;
    end

    assign EX_Branch_o = valid_q;
    assign update_o    = update;
    assign rbk_o       = rbk;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (valid_q),
        .cnt_o (branch_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (rbk),
        .cnt_o (mispred_cnt_o)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit built with 4-bit statistics counters so that
// saturation is reachable quickly.
module tb_branch_resolve_unit;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic              ex_branch;
    logic [1:0]        update;
    logic              rbk;
    logic [ADDR_W-1:0] rbk_addr;
    logic [CNT_W-1:0]  bcnt;
    logic [CNT_W-1:0]  mcnt;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              stall_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              ID_Branch_i = 1'b0;
  logic [ADDR_W-1:0] ID_pc_i = '0;
  logic [ADDR_W-1:0] ID_target_i = '0;
  logic [1:0]        state_i = 2'b00;
  logic              EX_taken_i = 1'b0;
  logic              EX_Branch_o;
  logic [1:0]        update_o;
  logic              rbk_o;
  logic [ADDR_W-1:0] rbk_addr_o;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispred_cnt_o;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .INIT_STATE(2'b11)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .ID_Branch_i   (ID_Branch_i),
    .ID_pc_i       (ID_pc_i),
    .ID_target_i   (ID_target_i),
    .state_i       (state_i),
    .EX_taken_i    (EX_taken_i),
    .EX_Branch_o   (EX_Branch_o),
    .update_o      (update_o),
    .rbk_o         (rbk_o),
    .rbk_addr_o    (rbk_addr_o),
    .branch_cnt_o  (branch_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  // reference model of the EX slot and counters
  logic              m_valid = 1'b0;
  logic [ADDR_W-1:0] m_pc = '0;
  logic [ADDR_W-1:0] m_target = '0;
  logic [1:0]        m_state = 2'b11;
  logic              m_pred = 1'b1;
  logic [CNT_W-1:0]  m_bcnt = '0;
  logic [CNT_W-1:0]  m_mcnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] st, input logic tk);
    case ({st, tk})
      3'b000: return 2'b00;
      3'b001: return 2'b01;
      3'b010: return 2'b00;
      3'b011: return 2'b10;
      3'b100: return 2'b01;
      3'b101: return 2'b11;
      3'b110: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && v != {CNT_W{1'b1}}) return v + 1'b1;
    return v;
  endfunction

  // One cycle: drive inputs, predict outputs, compare, advance the model.
  task automatic step(input logic rst, input logic idb, input logic [ADDR_W-1:0] pc,
                      input logic [ADDR_W-1:0] tgt, input logic [1:0] st,
                      input logic stall, input logic flush, input logic tk);
    exp_t e;
    exp_t got;
    logic cap;
    logic [1:0] cap_st;
    @(posedge clk_i);
    #1;
    rst_i = rst; ID_Branch_i = idb; ID_pc_i = pc; ID_target_i = tgt;
    state_i = st; stall_i = stall; flush_i = flush; EX_taken_i = tk;
    e.ex_branch = m_valid;
    e.update    = m_valid ? model_next(m_state, tk) : m_state;
    e.rbk       = m_valid && (m_pred != tk);
    if (!e.rbk)      e.rbk_addr = '0;
    else if (m_pred) e.rbk_addr = m_pc + 32'd4;
    else             e.rbk_addr = m_target;
    e.bcnt = m_bcnt;
    e.mcnt = m_mcnt;
    exp_q.push_back(e);
    #3;
    got = exp_q.pop_front();
    check("ex_branch", 64'(EX_Branch_o), 64'(got.ex_branch));
    check("update", 64'(update_o), 64'(got.update));
    check("rbk", 64'(rbk_o), 64'(got.rbk));
    check("rbk_addr", 64'(rbk_addr_o), 64'(got.rbk_addr));
    check("branch_cnt", 64'(branch_cnt_o), 64'(got.bcnt));
    check("mispred_cnt", 64'(mispred_cnt_o), 64'(got.mcnt));
    cap    = idb && !stall && !flush && !e.rbk;
    cap_st = m_valid ? e.update : st;
    if (rst) begin
      m_valid = 1'b0; m_pc = '0; m_target = '0; m_state = 2'b11; m_pred = 1'b1;
      m_bcnt = '0; m_mcnt = '0;
    end else begin
      m_bcnt = sat_inc(m_bcnt, m_valid);
      m_mcnt = sat_inc(m_mcnt, e.rbk);
      m_valid = cap;
      if (cap) begin
        m_pc = pc; m_target = tgt; m_state = cap_st; m_pred = cap_st[1];
      end
    end
  endtask

  task automatic idle(input logic tk);
    step(1'b0, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, tk);
  endtask

  task automatic branch(input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] tgt,
                        input logic [1:0] st, input logic tk);
    step(1'b0, 1'b1, pc, tgt, st, 1'b0, 1'b0, tk);
  endtask

  initial begin
    // reset and reset-state outputs
    step(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    // correctly predicted taken
    branch(32'h100, 32'h140, 2'b11, 1'b0);
    idle(1'b1);
    // mispredicted not-taken with a concurrent ID branch that must be dropped
    branch(32'h100, 32'h140, 2'b11, 1'b0);
    branch(32'h300, 32'h340, 2'b11, 1'b0);
    idle(1'b0);

    // weak-NT predicted, actually taken -> rollback to target
    branch(32'h1F0, 32'h200, 2'b01, 1'b0);
    idle(1'b1);
    // strong-NT resolves NT: saturate at 00
    branch(32'h210, 32'h400, 2'b00, 1'b0);
    idle(1'b0);

    // back-to-back: second captures forwarded state
    branch(32'h500, 32'h540, 2'b10, 1'b0);
    branch(32'h504, 32'h580, 2'b10, 1'b1);
    idle(1'b1);
    idle(1'b0);

    // stall then release: captured exactly once
    step(1'b0, 1'b1, 32'h600, 32'h640, 2'b11, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h600, 32'h640, 2'b11, 1'b1, 1'b0, 1'b0);
    branch(32'h600, 32'h640, 2'b11, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // flush squashes the ID branch
    step(1'b0, 1'b1, 32'h700, 32'h740, 2'b11, 1'b0, 1'b1, 1'b0);
    idle(1'b0);

    // pc+4 wraps at the top of the address space
    branch(32'hFFFF_FFFC, 32'h10, 2'b11, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 32'hFFFF)) << 2, 32'($urandom_range(0, 32'hFFFF)) << 2,
           2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    // counter saturation: 20 mispredicts on 4-bit counters
    step(1'b1, 1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      branch(32'h800 + 32'(i * 8), 32'h900, 2'b11, 1'b0);
      idle(1'b0);
    end
    idle(1'b0);
    check("branch_cnt_sat", 64'(branch_cnt_o), 64'hF);
    check("mispred_cnt_sat", 64'(mispred_cnt_o), 64'hF);

    // reset while a branch is resolving
    branch(32'hA00, 32'hA40, 2'b11, 1'b0);
    step(1'b1, 1'b1, 32'hB00, 32'hB40, 2'b11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
